// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multi-cycle RV32M divide unit:
//   - N         : operand / result width
//   - CNT_W     : width of the iteration counter
//   - INT_MIN   : most negative signed value (overflow detection)
//   - mdu_op_e  : operation encodings (DIV, DIVU, REM, REMU)
//   - mdu_state_e : FSM state encoding
//   - helpers to classify an operation (signed? quotient or remainder?)
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int N     = 32;
    localparam int CNT_W = $clog2(N);

    localparam logic [N-1:0] INT_MIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        MDU_DIV  = 2'b00,
        MDU_DIVU = 2'b01,
        MDU_REM  = 2'b10,
        MDU_REMU = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_signed(input mdu_op_e op_i);
        return (op_i == MDU_DIV) || (op_i == MDU_REM);
    endfunction

    function automatic logic op_is_quotient(input mdu_op_e op_i);
        return (op_i == MDU_DIV) || (op_i == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   rem_i, quo_i : current {remainder, quotient} pair
//   div_i        : divisor (magnitude)
//   rem_o, quo_o : pair after shifting left one bit and trying a subtract
// The pair is shifted left, the remainder's new LSB comes from the quotient
// MSB, and the trial subtraction is done at N+1 bits so its MSB is a clean
// "went negative" indicator.
// -----------------------------------------------------------------------------
module div_step
    import mdu_pkg::*;
(
    input  logic [N-1:0] rem_i,
    input  logic [N-1:0] quo_i,
    input  logic [N-1:0] div_i,
    output logic [N-1:0] rem_o,
    output logic [N-1:0] quo_o
);

    logic [N:0] trial;

    always_comb begin
        trial = {rem_i, quo_i[N-1]} - {1'b0, div_i};
        if (!trial[N]) begin
            rem_o = trial[N-1:0];
        end else begin
            rem_o = {rem_i[N-2:0], quo_i[N-1]};
        end
        quo_o = {quo_i[N-2:0], ~trial[N]};
    end

endmodule

// File: rtl/mdu_divider.sv
// -----------------------------------------------------------------------------
// mdu_divider
// Multi-cycle RV32M divider (DIV, DIVU, REM, REMU), restoring shift-subtract,
// one quotient bit per cycle, start/busy/done handshake.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, accepted only in IDLE
//   A, B, op   : dividend, divisor, operation (sampled with start)
//   busy       : operation in progress (starts ignored)
//   done       : one-cycle pulse, result valid
//   result     : quotient / remainder, held until the next completion
//   zeroflag   : result == 0, registered alongside result
// Optional build macro MDU_DIV_FASTPATH_EN: divide-by-zero and signed overflow
// are detected at load and jump straight to FIN, skipping the iterations.
// -----------------------------------------------------------------------------
module mdu_divider
    import mdu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [1:0]   op,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         zeroflag
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mdu_op_e          op_q, op_d;
    logic             a_neg_q, a_neg_d;
    logic             sign_diff_q, sign_diff_d;
    logic [N-1:0]     a_raw_q, a_raw_d;
    logic [N-1:0]     b_raw_q, b_raw_d;
    logic [N-1:0]     rem_q, rem_d;
    logic [N-1:0]     quo_q, quo_d;
    logic [N-1:0]     div_q, div_d;
    logic [N-1:0]     result_q, result_d;
    logic             zeroflag_q, zeroflag_d;
    logic             done_q, done_d;

    mdu_op_e      op_in;
    logic         in_signed;
    logic [N-1:0] a_abs, b_abs;
    logic [N-1:0] step_rem, step_quo;
    logic [N-1:0] quo_fix, rem_fix, fin_result;
    logic         fin_bzero, fin_ovf;

    assign op_in     = mdu_op_e'(op);
    assign in_signed = op_is_signed(op_in);
    assign a_abs     = (in_signed && A[N-1]) ? -A : A;
    assign b_abs     = (in_signed && B[N-1]) ? -B : B;

`ifdef MDU_DIV_FASTPATH_EN
    logic in_special;
    assign in_special = (B == '0) || (in_signed && (A == INT_MIN) && (B == '1));
`endif

    div_step u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Sign fix-up and RISC-V special cases, evaluated from the raw operands so
    // the same logic serves both the iterated and the fast-path flows.
    always_comb begin
        quo_fix   = sign_diff_q ? -quo_q : quo_q;
        rem_fix   = a_neg_q ? -rem_q : rem_q;
        fin_bzero = (b_raw_q == '0);
        fin_ovf   = op_is_signed(op_q) && (a_raw_q == INT_MIN) && (b_raw_q == '1);
        if (op_is_quotient(op_q)) begin
            fin_result = fin_bzero ? '1 : (fin_ovf ? a_raw_q : quo_fix);
        end else begin
            fin_result = fin_bzero ? a_raw_q : (fin_ovf ? '0 : rem_fix);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef MDU_DIV_FASTPATH_EN
                    state_d = in_special ? ST_FIN : ST_RUN;
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_RUN:  if (cnt_q == CNT_W'(N-1)) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: all straight from flops
    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = done_q;
        result   = result_q;
        zeroflag = zeroflag_q;
    end

    // Datapath next values
    always_comb begin
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_neg_d     = a_neg_q;
        sign_diff_d = sign_diff_q;
        a_raw_d     = a_raw_q;
        b_raw_d     = b_raw_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        result_d    = result_q;
        zeroflag_d  = zeroflag_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d        = op_in;
                    a_neg_d     = in_signed & A[N-1];
                    sign_diff_d = in_signed & (A[N-1] ^ B[N-1]);
                    a_raw_d     = A;
                    b_raw_d     = B;
                    rem_d       = '0;
                    quo_d       = a_abs;
                    div_d       = b_abs;
                    cnt_d       = '0;
                end
            end
            ST_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
            end
            ST_FIN: begin
                result_d   = fin_result;
                zeroflag_d = (fin_result == '0);
                done_d     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            op_q        <= MDU_DIV;
            a_neg_q     <= 1'b0;
            sign_diff_q <= 1'b0;
            a_raw_q     <= '0;
            b_raw_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            result_q    <= '0;
            zeroflag_q  <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_neg_q     <= a_neg_d;
            sign_diff_q <= sign_diff_d;
            a_raw_q     <= a_raw_d;
            b_raw_q     <= b_raw_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            result_q    <= result_d;
            zeroflag_q  <= zeroflag_d;
            done_q      <= done_d;
        end
    end

endmodule
